// File: rtl/vga_timing_out.sv
// vga_timing_out: scan counters, delayed sync/active flags and blanked RGB output stage.
//   clk, rst (async active-low), pix_en (advance enable)
//   draw_r/g/b    colour for the coordinate issued PIPE_DLY advances earlier
//   curr_x/curr_y scan coordinates, frame_start at (0,0) on a qualified cycle
//   hsync/vsync/active/pix_r/g/b registered outputs, aligned to each other
module vga_timing_out #(
    parameter int   H_ACTIVE = 1440,
    parameter int   H_FP     = 80,
    parameter int   H_SYNC   = 152,
    parameter int   H_BP     = 232,
    parameter int   V_ACTIVE = 900,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 28,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b1,
    parameter int   PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [3:0]  draw_r,
    input  logic [3:0]  draw_g,
    input  logic [3:0]  draw_b,
    output logic [10:0] curr_x,
    output logic [10:0] curr_y,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b
);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);

    // flag bundles are {act, hs, vs}
    logic [2:0] raw, dly;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            curr_x <= '0;
            curr_y <= '0;
        end else if (pix_en) begin
            curr_x <= (curr_x == H_LAST) ? 11'd0 : curr_x + 11'd1;
            if (curr_x == H_LAST)
                curr_y <= (curr_y == V_LAST) ? 11'd0 : curr_y + 11'd1;
        end

    assign raw = {(curr_x < H_ACT) && (curr_y < V_ACT),
                  (curr_x >= HS_ON) && (curr_x < HS_OFF),
                  (curr_y >= VS_ON) && (curr_y < VS_OFF)};

    assign frame_start = pix_en && (curr_x == 11'd0) && (curr_y == 11'd0);

    // flags travel alongside the draw pipeline so they meet draw_* at the output register
    generate
        if (PIPE_DLY == 0) begin : g_bypass
            assign dly = raw;
        end else begin : g_pipe
            logic [2:0] sr [PIPE_DLY];
            always_ff @(posedge clk or negedge rst)
                if (!rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) sr[i] <= '0;
                end else if (pix_en) begin
                    sr[0] <= raw;
                    for (int i = 1; i < PIPE_DLY; i++) sr[i] <= sr[i-1];
                end
            assign dly = sr[PIPE_DLY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            active <= 1'b0;
            hsync  <= ~H_POL;
            vsync  <= ~V_POL;
            pix_r  <= '0;
            pix_g  <= '0;
            pix_b  <= '0;
        end else if (pix_en) begin
            active <= dly[2];
            hsync  <= dly[1] ? H_POL : ~H_POL;
            vsync  <= dly[0] ? V_POL : ~V_POL;
            pix_r  <= dly[2] ? draw_r : 4'd0;
            pix_g  <= dly[2] ? draw_g : 4'd0;
            pix_b  <= dly[2] ? draw_b : 4'd0;
        end
endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: directed checks of vga_timing_out.
//   u0: full horizontal timing, PIPE_DLY=2, vertical timing shrunk to 16 lines so a frame fits the run
//   u1: tiny 24x10 raster, PIPE_DLY=0, inverted sync polarities, used for 1-of-4 enable gating
module tb_vga_timing_out;
    localparam int HT0 = 1904;
    localparam int VT0 = 16;
    localparam int F0  = HT0 * VT0;
    localparam int HT1 = 24;
    localparam int VT1 = 10;
    localparam int F1  = HT1 * VT1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0;
    logic [3:0] dr0 = '0, dg0 = '0, db0 = '0;
    logic [3:0] dr1 = '0, dg1 = '0, db1 = '0;
    logic [10:0] x0, y0, x1, y1;
    logic fs0, hs0, vs0, ac0, fs1, hs1, vs1, ac1;
    logic [3:0] pr0, pg0, pb0, pr1, pg1, pb1;

    int tests = 0;
    int fails = 0;
    int n0 = 0;

    always #5 clk = ~clk;

    vga_timing_out #(.V_ACTIVE(11), .V_FP(1), .V_SYNC(3), .V_BP(1)) u0 (
        .clk(clk), .rst(rst), .pix_en(en0),
        .draw_r(dr0), .draw_g(dg0), .draw_b(db0),
        .curr_x(x0), .curr_y(y0), .frame_start(fs0),
        .hsync(hs0), .vsync(vs0), .active(ac0),
        .pix_r(pr0), .pix_g(pg0), .pix_b(pb0));

    vga_timing_out #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b0), .PIPE_DLY(0)) u1 (
        .clk(clk), .rst(rst), .pix_en(en1),
        .draw_r(dr1), .draw_g(dg1), .draw_b(db1),
        .curr_x(x1), .curr_y(y1), .frame_start(fs1),
        .hsync(hs1), .vsync(vs1), .active(ac1),
        .pix_r(pr1), .pix_g(pg1), .pix_b(pb1));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic adv0(input int k);
        en0 = 1'b1;
        repeat (k) tick();
        n0 += k;
    endtask

    task automatic test_reset();
        dr0 = 4'hF; dg0 = 4'hF; db0 = 4'hF;
        repeat (2) tick();
        rst = 1'b1;
        n0 = 0;
        adv0(2 * HT0 + 700);
        tests++;
        if (ac0 !== 1'b1 || pr0 !== 4'hF) begin
            fails++; $display("FAIL pre_reset_active got act=%b r=%h want act=1 r=f", ac0, pr0);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (x0 !== 11'd0 || y0 !== 11'd0) begin
            fails++; $display("FAIL reset_counters got (%0d,%0d) want (0,0)", x0, y0);
        end
        tests++;
        if ({ac0, pr0, pg0, pb0} !== 13'd0) begin
            fails++; $display("FAIL reset_pixels got act=%b rgb=%h%h%h want act=0 rgb=000", ac0, pr0, pg0, pb0);
        end
        tests++;
        if (hs0 !== 1'b1 || vs0 !== 1'b0) begin
            fails++; $display("FAIL reset_syncs got hs=%b vs=%b want hs=1 vs=0", hs0, vs0);
        end
        tests++;
        if (hs1 !== 1'b0 || vs1 !== 1'b1) begin
            fails++; $display("FAIL reset_syncs_inv got hs=%b vs=%b want hs=0 vs=1", hs1, vs1);
        end
        @(negedge clk);
        tests++;
        if (x0 !== 11'd0 || y0 !== 11'd0) begin
            fails++; $display("FAIL reset_hold got (%0d,%0d) want (0,0)", x0, y0);
        end
        rst = 1'b1;
        n0 = 0;
        #1;
        tests++;
        if (fs0 !== 1'b1) begin
            fails++; $display("FAIL release_fs got %b want 1", fs0);
        end
        adv0(1);
        tests++;
        if (x0 !== 11'd1 || y0 !== 11'd0 || fs0 !== 1'b0) begin
            fails++; $display("FAIL release_x1 got (%0d,%0d) fs=%b want (1,0) fs=0", x0, y0, fs0);
        end
        adv0(1);
        tests++;
        if (x0 !== 11'd2 || fs0 !== 1'b0) begin
            fails++; $display("FAIL release_x2 got x=%0d fs=%b want x=2 fs=0", x0, fs0);
        end
    endtask

    task automatic test_line_wrap();
        adv0(10 * HT0 + 1903 - n0);
        tests++;
        if (x0 !== 11'd1903 || y0 !== 11'd10) begin
            fails++; $display("FAIL line_end got (%0d,%0d) want (1903,10)", x0, y0);
        end
        adv0(1);
        tests++;
        if (x0 !== 11'd0 || y0 !== 11'd11 || fs0 !== 1'b0) begin
            fails++; $display("FAIL line_wrap got (%0d,%0d) fs=%b want (0,11) fs=0", x0, y0, fs0);
        end
    endtask

    task automatic test_frame_wrap();
        adv0(F0 - 1 - n0);
        tests++;
        if (x0 !== 11'd1903 || y0 !== 11'd15 || fs0 !== 1'b0) begin
            fails++; $display("FAIL frame_end got (%0d,%0d) fs=%b want (1903,15) fs=0", x0, y0, fs0);
        end
        adv0(1);
        n0 = 0;
        tests++;
        if (x0 !== 11'd0 || y0 !== 11'd0 || fs0 !== 1'b1) begin
            fails++; $display("FAIL frame_wrap got (%0d,%0d) fs=%b want (0,0) fs=1", x0, y0, fs0);
        end
    endtask

    // one full frame with draw held at FFF: every output checked against the raster definition
    task automatic test_full_frame();
        int m, mx, my;
        logic act, hs, vs;
        dr0 = 4'hF; dg0 = 4'hF; db0 = 4'hF;
        en0 = 1'b1;
        for (int i = 0; i < F0; i++) begin
            m  = (i - 3 + F0) % F0;
            mx = m % HT0;
            my = m / HT0;
            act = (mx < 1440) && (my < 11);
            hs  = (mx >= 1520) && (mx < 1672);
            vs  = (my >= 12) && (my < 15);
            tests++;
            if (x0 !== 11'(i % HT0) || y0 !== 11'(i / HT0)) begin
                fails++;
                if (fails <= 20) $display("FAIL frame_coord got (%0d,%0d) want (%0d,%0d)", x0, y0, i % HT0, i / HT0);
            end
            tests++;
            if (fs0 !== (i == 0)) begin
                fails++;
                if (fails <= 20) $display("FAIL frame_start at (%0d,%0d) got %b want %b", i % HT0, i / HT0, fs0, i == 0);
            end
            tests++;
            if ({ac0, hs0, vs0} !== {act, ~hs, vs}) begin
                fails++;
                if (fails <= 20) $display("FAIL flags for (%0d,%0d) got act/hs/vs=%b%b%b want %b%b%b", mx, my, ac0, hs0, vs0, act, ~hs, vs);
            end
            tests++;
            if ({pr0, pg0, pb0} !== (act ? 12'hFFF : 12'h000)) begin
                fails++;
                if (fails <= 20) $display("FAIL blank for (%0d,%0d) got %h%h%h want %h", mx, my, pr0, pg0, pb0, act ? 12'hFFF : 12'h000);
            end
            tick();
        end
    endtask

    task automatic test_latency();
        int c;
        dr0 = 4'h0; dg0 = 4'h0; db0 = 4'h0;
        adv0(2 * HT0 + 95);
        for (int i = 0; i < 16; i++) begin
            c = 95 + i;
            tests++;
            if (pr0 !== ((c == 103) ? 4'h5 : 4'h0) || ac0 !== 1'b1) begin
                fails++; $display("FAIL latency2 at x=%0d got r=%h act=%b want r=%h act=1", c, pr0, ac0, (c == 103) ? 4'h5 : 4'h0);
            end
            dr0 = (c == 102) ? 4'h5 : 4'h0;
            adv0(1);
        end
        dr0 = 4'h0;
    endtask

    // 1-of-4 enable on the PIPE_DLY=0 instance; draw is garbage on unqualified cycles
    task automatic test_enable_pipe0();
        int k, m, mx, my, kx, ky;
        logic act, hs, vs;
        logic [3:0] er;
        k = 0;
        en0 = 1'b0;
        for (int t = 0; t < (2 * F1 + 6) * 4; t++) begin
            kx = k % HT1;
            ky = (k / HT1) % VT1;
            en1 = (t % 4 == 0);
            dr1 = en1 ? ((kx == 5 && ky == 2) ? 4'h5 : 4'h3) : 4'($urandom_range(15, 0));
            dg1 = en1 ? 4'hF : 4'($urandom_range(15, 0));
            db1 = en1 ? 4'hF : 4'($urandom_range(15, 0));
            #1;
            m  = (k - 1) % F1;
            mx = m % HT1;
            my = m / HT1;
            act = (k > 0) && (mx < 16) && (my < 6);
            hs  = (k > 0) && (mx >= 18) && (mx < 22);
            vs  = (k > 0) && (my >= 7) && (my < 9);
            er  = act ? ((mx == 5 && my == 2) ? 4'h5 : 4'h3) : 4'h0;
            tests++;
            if (x1 !== 11'(kx) || y1 !== 11'(ky)) begin
                fails++;
                if (fails <= 20) $display("FAIL en_coord t=%0d got (%0d,%0d) want (%0d,%0d)", t, x1, y1, kx, ky);
            end
            tests++;
            if (fs1 !== (en1 && kx == 0 && ky == 0)) begin
                fails++;
                if (fails <= 20) $display("FAIL en_frame_start t=%0d got %b want %b", t, fs1, en1 && kx == 0 && ky == 0);
            end
            tests++;
            if ({ac1, hs1, vs1} !== {act, hs, ~vs}) begin
                fails++;
                if (fails <= 20) $display("FAIL en_flags t=%0d got act/hs/vs=%b%b%b want %b%b%b", t, ac1, hs1, vs1, act, hs, ~vs);
            end
            tests++;
            if ({pr1, pg1, pb1} !== {er, act ? 8'hFF : 8'h00}) begin
                fails++;
                if (fails <= 20) $display("FAIL en_pix t=%0d got %h%h%h want %h%h", t, pr1, pg1, pb1, er, act ? 8'hFF : 8'h00);
            end
            @(posedge clk);
            if (en1) k++;
            @(negedge clk);
        end
        en1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_frame_wrap();
        test_full_frame();
        test_latency();
        test_enable_pipe0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
